// File: rtl/debounce_pkg.sv
// Shared state encodings and parameter legality check for debounce_sync.
// Used by debounce_sync, including the DEBOUNCE_EDGE_EN build.
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_STABLE_LO = 2'd0,
      ST_WAIT_HI   = 2'd1,
      ST_STABLE_HI = 2'd2,
      ST_WAIT_LO   = 2'd3
   } state_e;

   // The counter only has to reach STABLE_CYCLES-1, so clog2 bits are enough.
   function automatic bit params_legal(input int unsigned sync_stages,
                                       input int unsigned stable_cycles,
                                       input int unsigned cnt_w);
      return (sync_stages >= 2) && (stable_cycles >= 2) &&
             (cnt_w >= 1) && (cnt_w >= $clog2(stable_cycles));
   endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchronizer for a single asynchronous bit; all stages reset to RST_VAL.
module sync_chain #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes and debounces a raw 1-bit input; q follows only after STABLE_CYCLES steady clocks.
// Define DEBOUNCE_EDGE_EN to get registered rise/fall pulses; otherwise they are tied low.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 1000,
   parameter int unsigned CNT_W         = 16,
   parameter logic        RST_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic q,
   output logic busy,
   output logic rise,
   output logic fall
);

   localparam state_e           RST_STATE = RST_VAL ? ST_STABLE_HI : ST_STABLE_LO;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);

   generate
      if (!params_legal(SYNC_STAGES, STABLE_CYCLES, CNT_W)) begin : g_bad_params
         $error("debounce_sync: illegal SYNC_STAGES/STABLE_CYCLES/CNT_W combination");
      end
   endgenerate

   logic             d_sync;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;

   sync_chain #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (RST_VAL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (d_in),
      .q   (d_sync)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      q_d     = q_q;
      case (state_q)
         ST_STABLE_LO, ST_STABLE_HI: begin
            if (d_sync != q_q) begin
               state_d = q_q ? ST_WAIT_LO : ST_WAIT_HI;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_WAIT_HI, ST_WAIT_LO: begin
            if (d_sync == q_q) begin
               state_d = q_q ? ST_STABLE_HI : ST_STABLE_LO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = d_sync ? ST_STABLE_HI : ST_STABLE_LO;
               q_d     = d_sync;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = RST_STATE;
            q_d     = RST_VAL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         q_q     <= RST_VAL;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
      end
   end

   assign q    = q_q;
   assign busy = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   // Pulses are registered alongside q so they coincide with the q change.
   always_comb begin
      rise_d = !q_q &&  q_d;
      fall_d =  q_q && !q_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Self-checking bench for debounce_sync: directed scenarios plus randomized input against a run-length model.
// Expected rise/fall follow DEBOUNCE_EDGE_EN.
module tb_debounce_sync;

   localparam int unsigned SYNC = 2;
   localparam int unsigned STAB = 4;
`ifdef DEBOUNCE_EDGE_EN
   localparam logic EDGE_EN = 1'b1;
`else
   localparam logic EDGE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic d_in = 1'b1;
   logic q, busy, rise, fall;

   int unsigned checks = 0;
   int unsigned errors = 0;

   debounce_sync #(
      .SYNC_STAGES   (SYNC),
      .STABLE_CYCLES (STAB),
      .CNT_W         (4),
      .RST_VAL       (1'b0)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .d_in (d_in),
      .q    (q),
      .busy (busy),
      .rise (rise),
      .fall (fall)
   );

   always #5 clk = ~clk;

   // Reference: d_sync is d_in delayed SYNC edges; q flips once d_sync has
   // disagreed with q for STAB consecutive edges.
   logic        hist [SYNC];
   logic        m_q, m_rise, m_fall, m_valid = 1'b0;
   int unsigned run;

   always @(posedge clk) begin
      logic ds;
      if (rst) begin
         for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
         m_q = 1'b0; run = 0; m_rise = 1'b0; m_fall = 1'b0; m_valid = 1'b1;
      end else begin
         ds = hist[SYNC-1];
         for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = d_in;
         m_rise = 1'b0; m_fall = 1'b0;
         if (ds != m_q) begin
            run++;
            if (run == STAB) begin
               m_q = ds; run = 0; m_rise = ds; m_fall = !ds;
            end
         end else begin
            run = 0;
         end
      end
   end

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_q", q, m_q);
         chk("model_busy", busy, run != 0);
         chk("model_rise", rise, m_rise & EDGE_EN);
         chk("model_fall", fall, m_fall & EDGE_EN);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // 1: reset held with d_in high
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_q", q, 1'b0);
         chk("rst_busy", busy, 1'b0);
         chk("rst_rise", rise, 1'b0);
         chk("rst_fall", fall, 1'b0);
      end
      rst = 1'b0; d_in = 1'b0;
      repeat (8) tick();

      // 2: clean 0->1, q at edge 6
      d_in = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         if (e >= 3 && e <= 5) chk("s2_busy_hi", busy, 1'b1);
         if (e < 6) chk("s2_q_lo", q, 1'b0);
         if (e == 6) begin
            chk("s2_q_hi", q, 1'b1);
            chk("s2_rise", rise, EDGE_EN);
            chk("s2_busy_lo", busy, 1'b0);
         end
         if (e == 7) chk("s2_rise_end", rise, 1'b0);
      end

      // 3: short pulse from q=0 is rejected
      d_in = 1'b0;
      repeat (10) tick();
      d_in = 1'b1;
      repeat (2) tick();
      d_in = 1'b0;
      for (int e = 0; e < 10; e++) begin
         tick();
         chk("s3_q", q, 1'b0);
         chk("s3_rise", rise, 1'b0);
      end
      chk("s3_busy", busy, 1'b0);

      // 4: bounce, last toggle settles high
      for (int i = 0; i < 10; i++) begin
         d_in = ~d_in;
         tick();
         chk("s4_bounce_q", q, 1'b0);
      end
      d_in = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         tick();
         chk("s4_q", q, (e == 6) ? 1'b1 : 1'b0);
      end
      repeat (4) tick();

      // 5a: 1->0 with single fall pulse
      d_in = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk("s5_q", q, (e >= 6) ? 1'b0 : 1'b1);
         chk("s5_fall", fall, (e == 6) ? EDGE_EN : 1'b0);
      end

      // 5b: reset mid-WAIT_LO abandons the count
      d_in = 1'b1;
      repeat (10) tick();
      chk("s5b_q_hi", q, 1'b1);
      d_in = 1'b0;
      repeat (4) tick();
      chk("s5b_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      chk("s5b_rst_q", q, 1'b0);
      chk("s5b_rst_busy", busy, 1'b0);
      chk("s5b_rst_fall", fall, 1'b0);
      rst = 1'b0;
      for (int e = 0; e < 8; e++) begin
         tick();
         chk("s5b_after_q", q, 1'b0);
         chk("s5b_after_fall", fall, 1'b0);
      end

      // Randomized segments with occasional reset
      for (int seg = 0; seg < 600; seg++) begin
         int unsigned len;
         d_in = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 9);
         for (int c = 0; c < int'(len); c++) begin
            rst = ($urandom_range(0, 63) == 0);
            tick();
         end
      end
      rst = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
